// File: rtl/mfp_ahb_sprite_table_reader.sv
// Purpose: AHB-Lite read-back of a shadow copy of the sprite table, plus a video status window.
// Latency: read data is presented one cycle after the address phase; writes land at the end of the data phase.
// Backpressure: none; HREADYOUT tied high. Optional vblank interrupt with macro SPRITE_READER_VBLANK_IRQ_EN.
module mfp_ahb_sprite_table_reader #(
  parameter int TABLE_WORDS      = 512,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int VISIBLE_ROWS     = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [11:0] pix_row,
  input  logic        vert_sync,
  output logic        vblank_irq
);

  localparam int          IDX_W   = $clog2(TABLE_WORDS);
  localparam logic [11:0] VIS_ROW = 12'(VISIBLE_ROWS);

  // Address-phase decode
  logic             a_vld;
  logic             a_rd;
  logic             a_wr;
  logic             a_tbl;
  logic [IDX_W-1:0] a_idx;
  logic [1:0]       a_reg;

  // Table write pipeline and shadow storage
  logic             wr_pend;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      mem [TABLE_WORDS];
  logic [31:0]      ram_q;

  // Read-data registers: either the RAM output or a captured word
  logic             sel_ram_q;
  logic             sel_ram_nxt;
  logic [31:0]      rd_q;
  logic [31:0]      rd_nxt;

  // Video status
  logic [11:0]      pix_row_q;
  logic             vblank;
  logic             vs_now;
  logic             vs_q;
  logic             vs_rise;
  logic [15:0]      frame_cnt;
  logic             irq_bit;
  logic [31:0]      status_word;

  // Address bits outside the decoded fields and HTRANS[0] carry no meaning here
  logic             unused_bits;
  assign unused_bits = ^{HADDR[31:12], HADDR[1:0], HTRANS[0]};

  assign a_vld = HSEL & HTRANS[1];
  assign a_rd  = a_vld & ~HWRITE;
  assign a_wr  = a_vld & HWRITE;
  assign a_tbl = ~HADDR[11];
  assign a_idx = HADDR[IDX_W+1:2];
  assign a_reg = HADDR[3:2];

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Normalise sync polarity so the edge detector always looks for a rising "asserted"
  assign vs_now  = VSYNC_ACTIVE_LOW ? ~vert_sync : vert_sync;
  assign vs_rise = vs_now & ~vs_q;

  assign status_word = {frame_cnt, 14'b0, irq_bit, vblank};

  // Select what the next data phase returns; a read hitting the in-flight write
  // takes the bus data directly because the RAM still holds the old word.
  always_comb begin
    rd_nxt      = '0;
    sel_ram_nxt = 1'b0;
    if (a_rd) begin
      if (a_tbl) begin
        if (wr_pend && (a_idx == wr_idx)) begin
          rd_nxt = HWDATA;
        end else begin
          sel_ram_nxt = 1'b1;
        end
      end else begin
        case (a_reg)
          2'd0:    rd_nxt = status_word;
          2'd1:    rd_nxt = {20'b0, pix_row_q};
          default: rd_nxt = '0;
        endcase
      end
    end
  end

  // Bus-side pipeline registers: pending write and registered read selection
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend   <= 1'b0;
      wr_idx    <= '0;
      sel_ram_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      wr_pend   <= a_wr & a_tbl;
      wr_idx    <= a_idx;
      sel_ram_q <= sel_ram_nxt;
      rd_q      <= rd_nxt;
    end
  end

  // Shadow RAM: write in the data phase, synchronous read in the address phase.
  // Reset during the data phase drops the write.
  always_ff @(posedge clk) begin
    if (wr_pend && !rst) begin
      mem[wr_idx] <= HWDATA;
    end
    if (a_rd && a_tbl) begin
      ram_q <= mem[a_idx];
    end
  end

  assign HRDATA = sel_ram_q ? ram_q : rd_q;

  // Video timing: row capture, vblank flag, and frame counter on sync assertion
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_row_q <= '0;
      vblank    <= 1'b0;
      vs_q      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pix_row_q <= pix_row;
      vblank    <= (pix_row_q >= VIS_ROW);
      vs_q      <= vs_now;
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef SPRITE_READER_VBLANK_IRQ_EN
  logic stat_wr_pend;
  logic vblank_d;
  logic irq_flag;

  // Sticky vblank interrupt; a new vblank edge wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_pend <= 1'b0;
      vblank_d     <= 1'b0;
      irq_flag     <= 1'b0;
    end else begin
      stat_wr_pend <= a_wr & ~a_tbl & (a_reg == 2'd0);
      vblank_d     <= vblank;
      if (vblank && !vblank_d) begin
        irq_flag <= 1'b1;
      end else if (stat_wr_pend && HWDATA[0]) begin
        irq_flag <= 1'b0;
      end
    end
  end

  assign irq_bit    = irq_flag;
  assign vblank_irq = irq_flag;
`else
  assign irq_bit    = 1'b0;
  assign vblank_irq = 1'b0;
`endif

endmodule

// File: tb/tb_mfp_ahb_sprite_table_reader.sv
// Purpose: directed self-checking bench for mfp_ahb_sprite_table_reader.
// Latency: each bus step drives one address phase and samples HRDATA 1 ns after the next edge.
// Backpressure: the DUT never stalls, so every step is exactly one clock.
module tb_mfp_ahb_sprite_table_reader;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [11:0] pix_row;
  logic        vert_sync;
  logic        vblank_irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mfp_ahb_sprite_table_reader dut (
    .clk        (clk),
    .rst        (rst),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .pix_row    (pix_row),
    .vert_sync  (vert_sync),
    .vblank_irq (vblank_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one address phase together with the data-phase HWDATA of the previous transfer
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata);
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = addr;
    HWDATA = wdata;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic vs_pulse();
    vert_sync = 1'b0;
    tick();
    vert_sync = 1'b1;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    HSEL      = 1'b0;
    HADDR     = '0;
    HTRANS    = T_IDLE;
    HWRITE    = 1'b0;
    HWDATA    = '0;
    pix_row   = 12'd0;
    vert_sync = 1'b1;
    repeat (3) tick();

    chk("rst_hrdata",    HRDATA,            32'h0);
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("rst_hresp",     {31'b0, HRESP},     32'h0);
    chk("rst_irq",       {31'b0, vblank_irq}, 32'h0);
    rst = 1'b0;

    // Status window straight out of reset
    cyc(1'b1, T_NS, 1'b0, 32'h800, 32'h0);
    chk("rst_status", HRDATA, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 32'h808, 32'h0);
    chk("reserved_reg", HRDATA, 32'h0);

    // Write word 5 then read it back after a gap
    cyc(1'b1, T_NS,   1'b1, 32'h014, 32'h0);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0,   32'h00AB_1234);
    cyc(1'b1, T_NS,   1'b0, 32'h014, 32'h0);
    chk("rd_word5", HRDATA, 32'h00AB_1234);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    chk("idle_after_rd", HRDATA, 32'h0);

    // Write immediately followed by read of the same word: forwarded
    cyc(1'b1, T_NS, 1'b1, 32'h020, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 32'h020, 32'hDEAD_BEEF);
    chk("fwd_word8", HRDATA, 32'hDEAD_BEEF);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 32'h020, 32'h0);
    chk("later_word8", HRDATA, 32'hDEAD_BEEF);

    // write->write->read->read with no bubbles
    cyc(1'b1, T_NS, 1'b1, 32'h030, 32'h0);
    cyc(1'b1, T_NS, 1'b1, 32'h034, 32'h3030_A0A0);
    cyc(1'b1, T_NS, 1'b0, 32'h030, 32'h3434_B0B0);
    chk("ww_rd_word12", HRDATA, 32'h3030_A0A0);
    cyc(1'b1, T_NS, 1'b0, 32'h034, 32'h0);
    chk("rr_rd_word13", HRDATA, 32'h3434_B0B0);

    // read->write->read on one word: old value, then forwarded new value
    cyc(1'b1, T_NS, 1'b0, 32'h014, 32'h0);
    chk("rw_old_word5", HRDATA, 32'h00AB_1234);
    cyc(1'b1, T_NS, 1'b1, 32'h014, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 32'h014, 32'h5555_AAAA);
    chk("rw_new_word5", HRDATA, 32'h5555_AAAA);

    // IDLE/BUSY transfers with HWRITE set must not touch word 7
    cyc(1'b1, T_NS,   1'b1, 32'h01C, 32'h0);
    cyc(1'b1, T_IDLE, 1'b1, 32'h01C, 32'h7777_0007);
    chk("idle_wr_hrdata", HRDATA, 32'h0);
    cyc(1'b1, T_BUSY, 1'b1, 32'h01C, 32'hBAD0_BAD0);
    chk("busy_wr_hrdata", HRDATA, 32'h0);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0,   32'hBAD1_BAD1);
    cyc(1'b1, T_NS,   1'b0, 32'h01C, 32'h0);
    chk("word7_kept", HRDATA, 32'h7777_0007);
    cyc(1'b1, T_IDLE, 1'b0, 32'h01C, 32'h0);
    chk("idle_rd_zero", HRDATA, 32'h0);

    // Deselected read returns zero
    cyc(1'b1, T_NS, 1'b0, 32'h014, 32'h0);
    chk("rd_word5_again", HRDATA, 32'h5555_AAAA);
    cyc(1'b0, T_NS, 1'b0, 32'h014, 32'h0);
    chk("hsel0_zero", HRDATA, 32'h0);

    // Frame counter: three sync assertions, then up to 0xFFFF and wrap
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    repeat (3) vs_pulse();
    cyc(1'b1, T_NS, 1'b0, 32'h800, 32'h0);
    chk("frame_cnt_3", HRDATA, 32'h0003_0000);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    repeat (65532) vs_pulse();
    cyc(1'b1, T_NS, 1'b0, 32'h800, 32'h0);
    chk("frame_cnt_ffff", HRDATA, 32'hFFFF_0000);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    vs_pulse();
    cyc(1'b1, T_NS, 1'b0, 32'h800, 32'h0);
    chk("frame_cnt_wrap", HRDATA, 32'h0);

    // vblank threshold at row 480
    pix_row = 12'd479;
    repeat (3) cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 32'h800, 32'h0);
    chk("vblank_row479", {31'b0, HRDATA[0]}, 32'h0);
    pix_row = 12'd480;
    repeat (3) cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 32'h800, 32'h0);
    chk("vblank_row480", {31'b0, HRDATA[0]}, 32'h1);
`ifdef SPRITE_READER_VBLANK_IRQ_EN
    chk("status_irq_set", {31'b0, HRDATA[1]}, 32'h1);
    chk("irq_set", {31'b0, vblank_irq}, 32'h1);
`else
    chk("status_irq_off", {31'b0, HRDATA[1]}, 32'h0);
    chk("irq_off", {31'b0, vblank_irq}, 32'h0);
`endif
    cyc(1'b1, T_NS, 1'b0, 32'h804, 32'h0);
    chk("row_reg", HRDATA, 32'h0000_01E0);

`ifdef SPRITE_READER_VBLANK_IRQ_EN
    // Clear the sticky flag by writing 1 to STATUS
    cyc(1'b1, T_NS,   1'b1, 32'h800, 32'h0);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0,   32'h1);
    chk("irq_cleared", {31'b0, vblank_irq}, 32'h0);
`endif

    // Reset asserted during a write data phase drops the write
    cyc(1'b1, T_NS, 1'b1, 32'h014, 32'h0);
    rst = 1'b1;
    cyc(1'b1, T_NS, 1'b0, 32'h014, 32'hBADB_AD00);
    chk("rst_mid_hrdata", HRDATA, 32'h0);
    rst = 1'b0;
    cyc(1'b1, T_NS, 1'b0, 32'h014, 32'h0);
    chk("rst_mid_word5", HRDATA, 32'h5555_AAAA);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_sprite_table_reader.md
Name: mfp_ahb_sprite_table_reader

Overview:
- AHB-Lite read-back responder for the sprite table.
- The CPU-side sprite table path only writes, so software cannot read back sprite x/y/palette entries or see video timing. This block provides both.
- It keeps a shadow copy of all 512 sprite-table words by snooping AHB writes. It answers AHB reads from that copy or from a small video-status register window (vblank flag, current row, frame counter).
- It sits beside mfp_to_sprite_table_decoder on the same AHB bus and is clocked by the 25 MHz pixel clock.

Parameters:
- TABLE_WORDS, 512, shadow depth in 32-bit words; index = HADDR[10:2].
- VSYNC_ACTIVE_LOW, 1, polarity of vert_sync (1: sync asserted when 0).
- VISIBLE_ROWS, 480, first pix_row value treated as vertical blank.

Ports:
- clk  in  1  pixel/bus clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- HSEL  in  1  slave select for this block's address window
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type
- HWRITE  in  1  AHB write
- HWDATA  in  32  AHB write data (data phase)
- HRDATA  out  32  read data (data phase)
- HREADYOUT  out  1  always 1 (zero wait states)
- HRESP  out  1  always 0 (OKAY)
- pix_row  in  12  current row from dtg
- vert_sync  in  1  vertical sync from dtg
- vblank_irq  out  1  vblank interrupt (see Optional Feature)

Behaviour:
- Reset values: HRDATA=0, HREADYOUT=1, HRESP=0, vblank_irq=0, frame_cnt=0, vblank=0, pending write cleared. Shadow RAM contents are not reset.
- Valid transfer: HSEL & HTRANS[1] (NONSEQ/SEQ). IDLE and BUSY are ignored; they produce no state change and HRDATA=0 in the following data phase.
- Address decode:
  - HADDR[11]=0: table word at HADDR[10:2].
  - HADDR[11]=1, HADDR[3:2]=0: STATUS = {frame_cnt[15:0], 15'b0, vblank}.
  - HADDR[11]=1, HADDR[3:2]=1: ROW = {20'b0, pix_row_q}.
  - HADDR[11]=1, HADDR[3:2]=2 or 3: read 0.
  - HADDR[1:0] and HSIZE are ignored; all accesses are full word.
- Write: address phase latches wr_pend=1 and wr_idx. In the data phase, wr_pend causes RAM[wr_idx] <= HWDATA at the end of that cycle. Writes to the status window have no effect (except under the optional macro).
- Read: address phase issues a synchronous RAM read. HRDATA is valid in the next cycle (data phase, latency 1, no wait states). Status reads are registered identically.
- Hazard: a read address phase to wr_idx while wr_pend=1 forwards the current HWDATA to HRDATA next cycle. The stale RAM word is never returned.
- Back-to-back transfers: write->write, write->read and read->write are all sustained every cycle with no bubble.
- Video status:
  - pix_row registered into pix_row_q every cycle.
  - vblank = (pix_row_q >= VISIBLE_ROWS), registered.
  - frame_cnt: 16-bit, +1 on the sync-assertion edge of vert_sync (edge-detected with a one-cycle delay register); wraps 0xFFFF->0x0000.
- Reset mid-operation: a pending write is dropped and HRDATA returns 0 in the next cycle.

Optional Feature:
- Macro: SPRITE_READER_VBLANK_IRQ_EN.
- Defined:
  - A sticky irq_flag is set on the rising edge of vblank, and vblank_irq = irq_flag.
  - An AHB write to STATUS with HWDATA[0]=1 clears it. If set and clear coincide, set wins.
  - STATUS bit[1] reads irq_flag.
- Undefined: vblank_irq is tied 0, STATUS bit[1] reads 0, and status writes are ignored.

Test Plan:
- Write 0x00AB_1234 to word 5 (HADDR 0x014), then read 0x014 -> HRDATA=0x00AB_1234 one cycle after the read address phase.
- Back-to-back write 0xDEADBEEF to 0x020 immediately followed by a read of 0x020 -> forwarded HRDATA=0xDEADBEEF with no wait state; a later read also returns 0xDEADBEEF.
- Drive pix_row 479 then 480, read STATUS -> bit0 = 0 then 1; read ROW -> 0x1E0 after row 480 registered.
- Toggle vert_sync through 3 assertions from reset -> STATUS[31:16]=3; preload 0xFFFF via 65535 pulses, one more -> 0x0000.
- HTRANS=IDLE with HWRITE=1 to word 7 -> word 7 unchanged; HSEL=0 read -> HRDATA=0.
- With SPRITE_READER_VBLANK_IRQ_EN: vblank rises -> vblank_irq=1; write 0x1 to STATUS -> 0 next cycle. Assert rst during a write data phase -> target word unchanged and HRDATA=0.
